// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - UART remote controller: 16-bit command as two 8N1 bytes out, response bytes in
module remote_comm #(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

    typedef enum logic [1:0] {C_IDLE, C_SEND_HI, C_SEND_LO} cmd_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA} rx_state_t;

    cmd_state_t     cmd_state, cmd_nxt;
    logic [15:0]    cmd_lat;
    logic           accept, tx_load, tx_done;
    logic [7:0]     tx_byte;

    logic [9:0]     tx_shift;
    logic [3:0]     tx_bits;
    logic [CW-1:0]  tx_cnt;
    logic           tx_busy;

    rx_state_t      rx_state, rx_nxt;
    logic           rx_meta, rx_sync, rx_prev, rx_tick;
    logic [CW-1:0]  rx_cnt;
    logic [3:0]     rx_bits;
    logic [7:0]     rx_data;

    // Command sequencer: each byte is loaded the cycle after the engine goes idle.
    always_comb begin
        cmd_nxt = cmd_state;
        accept  = 1'b0;
        tx_load = 1'b0;
        tx_byte = cmd_lat[15:8];
        case (cmd_state)
            C_IDLE: begin
                if (snd_cmd) begin
                    accept  = 1'b1;
                    cmd_nxt = C_SEND_HI;
                end
            end
            C_SEND_HI: begin
                tx_load = !tx_busy;
                if (tx_done) cmd_nxt = C_SEND_LO;
            end
            C_SEND_LO: begin
                tx_load = !tx_busy;
                tx_byte = cmd_lat[7:0];
                if (tx_done) cmd_nxt = C_IDLE;
            end
            default: cmd_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cmd_state <= C_IDLE;
            cmd_lat   <= 16'h0000;
            cmd_snt   <= 1'b0;
        end else begin
            cmd_state <= cmd_nxt;
            if (accept) begin
                cmd_lat <= cmd;
                cmd_snt <= 1'b0;
            end else if (cmd_state == C_SEND_LO && tx_done) begin
                cmd_snt <= 1'b1;
            end
        end
    end

    // The shift register back-fills with ones, so TX sits high whenever nothing is queued.
    assign tx_done = tx_busy && (tx_cnt == BIT_END) && (tx_bits == 4'd9);
    assign TX      = tx_shift[0];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tx_shift <= 10'h3FF;
            tx_bits  <= 4'd0;
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
        end else if (tx_load) begin
            tx_shift <= {1'b1, tx_byte, 1'b0};
            tx_bits  <= 4'd0;
            tx_cnt   <= '0;
            tx_busy  <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == BIT_END) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_bits == 4'd9) tx_busy <= 1'b0;
                else                 tx_bits <= tx_bits + 4'd1;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign rx_tick = ((rx_state == R_START) && (rx_cnt == HALF_END)) ||
                     ((rx_state == R_DATA)  && (rx_cnt == BIT_END));

    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_prev && !rx_sync) rx_nxt = R_START;
            R_START: if (rx_tick) rx_nxt = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (rx_tick && rx_bits == 4'd8) rx_nxt = R_IDLE;
            default: rx_nxt = R_IDLE;
        endcase
    end

    // Eight data samples shift in; the ninth (stop) sample only triggers delivery.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= 4'd0;
            rx_data  <= 8'h00;
            resp     <= 8'h00;
            resp_rdy <= 1'b0;
        end else begin
            rx_meta  <= RX;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_nxt;
            resp_rdy <= 1'b0;
            if (rx_state == R_IDLE || rx_tick) rx_cnt <= '0;
            else                               rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == R_START) rx_bits <= 4'd0;
            if (rx_state == R_DATA && rx_tick) begin
                if (rx_bits == 4'd8) begin
                    resp     <= rx_data;
                    resp_rdy <= 1'b1;
                end else begin
                    rx_data <= {rx_sync, rx_data[7:1]};
                    rx_bits <= rx_bits + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - directed and randomized checks of remote_comm against a frame-level model
module tb_remote_comm;

    localparam int CPB   = 16;
    localparam int LIMIT = 20 * CPB + 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        TX;
    logic        RX;
    logic [7:0]  resp;
    logic        resp_rdy;

    int errors = 0;
    int checks = 0;
    logic wave [0:LIMIT];

    remote_comm #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
        .TX(TX), .RX(RX), .resp(resp), .resp_rdy(resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends a command, records TX every cycle, then checks bit cells, gap, completion time and a loopback decode.
    task automatic do_cmd(input logic [15:0] c, input int inject_at, input logic [15:0] junk);
        logic       exp_bits [0:19];
        logic [7:0] b;
        logic [7:0] dec;
        int         done_cyc;
        int         p;
        int         start;
        for (int f = 0; f < 2; f++) begin
            b = (f == 0) ? c[15:8] : c[7:0];
            exp_bits[f*10] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[f*10+1+i] = b[i];
            exp_bits[f*10+9] = 1'b1;
        end
        @(negedge clk);
        cmd = c;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1;
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
        wave[0] = TX;
        chk("cmd_snt_cleared", {31'd0, cmd_snt}, 32'd0);
        done_cyc = 0;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            @(posedge clk);
            #1;
            wave[cyc] = TX;
            if (cmd_snt === 1'b1 && done_cyc == 0) done_cyc = cyc;
            snd_cmd = (cyc == inject_at);
            if (cyc == inject_at) cmd = junk;
        end
        chk("cmd_snt_latency", done_cyc, 20 * CPB + 2);
        for (int k = 0; k < 20; k++) begin
            start = (k < 10) ? 1 : 10 * CPB + 2;
            chk($sformatf("tx_bit%0d", k), {31'd0, wave[start + (k % 10) * CPB + CPB / 2]},
                {31'd0, exp_bits[k]});
        end
        chk("tx_gap_idle", {31'd0, wave[10 * CPB + 1]}, 32'd1);
        p = 1;
        for (int f = 0; f < 2; f++) begin
            while (p < LIMIT - 10 * CPB && !(wave[p] === 1'b0 && wave[p-1] === 1'b1)) p++;
            dec = 8'hxx;
            if (p < LIMIT - 10 * CPB)
                for (int i = 0; i < 8; i++) dec[i] = wave[p + CPB / 2 + CPB * (i + 1)];
            chk($sformatf("loopback_byte%0d", f), {24'd0, dec}, {24'd0, (f == 0) ? c[15:8] : c[7:0]});
            p = p + 9 * CPB + CPB / 2;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] frame;
        logic [7:0] got;
        int         hi_cycles;
        frame = {1'b1, b, 1'b0};
        got = 8'h00;
        hi_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            repeat (CPB) begin
                @(negedge clk);
                if (resp_rdy === 1'b1) begin
                    hi_cycles++;
                    got = resp;
                end
                RX = frame[k];
            end
        end
        repeat (2 * CPB) begin
            @(negedge clk);
            if (resp_rdy === 1'b1) begin
                hi_cycles++;
                got = resp;
            end
        end
        chk("resp_rdy_one_cycle", hi_cycles, 1);
        chk("resp_value", {24'd0, got}, {24'd0, b});
        chk("resp_held", {24'd0, resp}, {24'd0, b});
    endtask

    task automatic rx_glitch(input logic [7:0] held);
        int hi_cycles;
        hi_cycles = 0;
        @(negedge clk);
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (resp_rdy === 1'b1) hi_cycles++;
        end
        chk("glitch_no_rdy", hi_cycles, 0);
        chk("glitch_resp_kept", {24'd0, resp}, {24'd0, held});
    endtask

    initial begin
        int         idle_bad;
        logic [7:0] rb;
        rst_n = 1'b1;
        cmd = 16'h0000;
        snd_cmd = 1'b0;
        RX = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, TX}, 32'd1);
        chk("rst_cmd_snt", {31'd0, cmd_snt}, 32'd0);
        chk("rst_resp", {24'd0, resp}, 32'd0);
        chk("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
        rst_n = 1'b0;
        idle_bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_snt !== 1'b0 || resp_rdy !== 1'b0) idle_bad++;
        end
        chk("idle_hold", idle_bad, 0);

        do_cmd(16'h23F1, -1, 16'h0000);
        do_cmd(16'h0000, -1, 16'h0000);
        send_rx(8'hA5);
        rx_glitch(8'hA5);
        do_cmd(16'h23F1, 5 * CPB, 16'h1234);
        do_cmd(16'h23F1, 15 * CPB, 16'hBEEF);

        @(negedge clk);
        cmd = 16'h23F1;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1;
        snd_cmd = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("tx_low_before_rst", {31'd0, TX}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("tx_high_in_rst", {31'd0, TX}, 32'd1);
        chk("cmd_snt_in_rst", {31'd0, cmd_snt}, 32'd0);
        chk("resp_in_rst", {24'd0, resp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        do_cmd(16'($urandom), -1, 16'h0000);

        for (int n = 0; n < 3; n++) do_cmd(16'($urandom), int'($urandom_range(2, 19 * CPB)), 16'($urandom));
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom);
            send_rx(rb);
        end
        rx_glitch(rb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
